// File: rtl/hdc_classify_ctrl_pkg.sv
// ==========================================================================
// hdc_classify_ctrl_pkg : shared types and constants for the HDC classifier
// sequencer (FSM states, token map, result codes).
// Revision: 1.0
// ==========================================================================
`default_nettype none

package hdc_classify_ctrl_pkg;

  localparam int NUM_CHAR        = 37;
  localparam int TOK_W           = 6;
  localparam int TOK_OTHER       = 0;
  localparam int TOK_DIGIT_BASE  = 1;
  localparam int TOK_LETTER_BASE = 11;

  localparam logic [1:0] RES_SPAM  = 2'b00;
  localparam logic [1:0] RES_HAM   = 2'b01;
  localparam logic [1:0] RES_UNDEC = 2'b11;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_CLR     = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_THRESH  = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DECIDE  = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/hdc_classify_ctrl_tokenizer.sv
// ==========================================================================
// hdc_classify_ctrl_tokenizer : combinational ASCII -> 6-bit token map.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module hdc_classify_ctrl_tokenizer
  import hdc_classify_ctrl_pkg::*;
(
  input  logic [7:0]       ch,
  output logic [TOK_W-1:0] token
);

  always_comb begin
    token = TOK_W'(TOK_OTHER);
    // Upper and lower case share the same letter tokens.
    if (ch >= 8'h61 && ch <= 8'h7a)
      token = TOK_W'(ch - 8'h61 + 8'(TOK_LETTER_BASE));
    else if (ch >= 8'h41 && ch <= 8'h5a)
      token = TOK_W'(ch - 8'h41 + 8'(TOK_LETTER_BASE));
    else if (ch >= 8'h30 && ch <= 8'h39)
      token = TOK_W'(ch - 8'h30 + 8'(TOK_DIGIT_BASE));
  end

endmodule

`default_nettype wire

// File: rtl/hdc_classify_ctrl.sv
// ==========================================================================
// hdc_classify_ctrl : buffers a tokenized message and sequences the chunked
// HV datapath through clear/accumulate/threshold/compare, then decides.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module hdc_classify_ctrl
  import hdc_classify_ctrl_pkg::*;
#(
  parameter  int MAX_LENGTH = 200,
  parameter  int DIM        = 10000,
  parameter  int CHUNK      = 100,
  parameter  int DIST_W     = 18,
  parameter  int DP_LAT     = 2,
  localparam int NCHUNK     = DIM / CHUNK,
  localparam int CW         = $clog2(NCHUNK),
  localparam int LW         = $clog2(MAX_LENGTH + 1),
  localparam int DRW        = (DP_LAT > 1) ? $clog2(DP_LAT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [7:0]        msg_char,
  input  logic              msg_last,
  output logic [TOK_W-1:0]  im_addr,
  output logic [CW-1:0]     chunk_idx,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              acc_last,
  output logic              thr_en,
  output logic              cmp_clr,
  output logic              cmp_en,
  input  logic [DIST_W-1:0] dist_ham,
  input  logic [DIST_W-1:0] dist_spam,
  output logic              busy,
  output logic              overflow,
  output logic              result_valid,
  output logic [1:0]        result
);

  state_t           state;
  logic [LW-1:0]    len;
  logic [LW-1:0]    tok_idx;
  logic [DRW-1:0]   drain_cnt;
  logic [TOK_W-1:0] token;
  logic [TOK_W-1:0] tok_mem [MAX_LENGTH];

  wire last_chunk = (chunk_idx == CW'(NCHUNK - 1));
  wire accept     = (state == ST_LOAD) && msg_valid;

  assign msg_ready = (state == ST_LOAD);
  assign busy      = (state != ST_LOAD);

  hdc_classify_ctrl_tokenizer u_tokenizer (
    .ch    (msg_char),
    .token (token)
  );

  // Token file carries no reset: contents are only read for indices below len.
  always_ff @(posedge clk) begin
    if (accept && (len < LW'(MAX_LENGTH)))
      tok_mem[len] <= token;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_LOAD;
      len          <= '0;
      tok_idx      <= '0;
      drain_cnt    <= '0;
      im_addr      <= '0;
      chunk_idx    <= '0;
      acc_clr      <= 1'b0;
      acc_en       <= 1'b0;
      acc_last     <= 1'b0;
      thr_en       <= 1'b0;
      cmp_clr      <= 1'b0;
      cmp_en       <= 1'b0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      result       <= RES_UNDEC;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (msg_valid) begin
            // len==0 marks the first char of a new message.
            if (len == '0)
              overflow <= 1'b0;
            if (len < LW'(MAX_LENGTH))
              len <= len + LW'(1);
            else
              overflow <= 1'b1;
            if (msg_last) begin
              state     <= ST_CLR;
              acc_clr   <= 1'b1;
              chunk_idx <= '0;
            end
          end
        end

        ST_CLR: begin
          if (last_chunk) begin
            state     <= ST_ACCUM;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b1;
            chunk_idx <= '0;
            tok_idx   <= '0;
            im_addr   <= tok_mem[0];
            acc_last  <= (len == LW'(1));
          end else begin
            chunk_idx <= chunk_idx + CW'(1);
          end
        end

        ST_ACCUM: begin
          if (last_chunk) begin
            chunk_idx <= '0;
            if (tok_idx == len - LW'(1)) begin
              state    <= ST_THRESH;
              acc_en   <= 1'b0;
              acc_last <= 1'b0;
              im_addr  <= '0;
              thr_en   <= 1'b1;
            end else begin
              tok_idx  <= tok_idx + LW'(1);
              im_addr  <= tok_mem[tok_idx + LW'(1)];
              acc_last <= ((tok_idx + LW'(1)) == (len - LW'(1)));
            end
          end else begin
            chunk_idx <= chunk_idx + CW'(1);
          end
        end

        ST_THRESH: begin
          if (last_chunk) begin
            state     <= ST_COMPARE;
            thr_en    <= 1'b0;
            cmp_en    <= 1'b1;
            cmp_clr   <= 1'b1;
            chunk_idx <= '0;
          end else begin
            chunk_idx <= chunk_idx + CW'(1);
          end
        end

        ST_COMPARE: begin
          cmp_clr <= 1'b0;
          if (last_chunk) begin
            state     <= ST_DRAIN;
            cmp_en    <= 1'b0;
            chunk_idx <= '0;
            drain_cnt <= '0;
          end else begin
            chunk_idx <= chunk_idx + CW'(1);
          end
        end

        ST_DRAIN: begin
          if (drain_cnt == DRW'(DP_LAT - 1))
            state <= ST_DECIDE;
          else
            drain_cnt <= drain_cnt + DRW'(1);
        end

        ST_DECIDE: begin
          if (dist_ham < dist_spam)
            result <= RES_HAM;
          else if (dist_ham > dist_spam)
            result <= RES_SPAM;
          else
            result <= RES_UNDEC;
          result_valid <= 1'b1;
          len          <= '0;
          state        <= ST_LOAD;
        end

        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hdc_classify_ctrl.sv
// ==========================================================================
// tb_hdc_classify_ctrl : directed bench; builds the expected per-cycle
// strobe schedule of each message and compares it against the DUT.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_hdc_classify_ctrl;

  localparam int NCH  = 100;
  localparam int DPL  = 2;
  localparam int MAXL = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [7:0]  msg_char = 8'h0;
  logic        msg_last = 1'b0;
  logic [5:0]  im_addr;
  logic [6:0]  chunk_idx;
  logic        acc_clr, acc_en, acc_last, thr_en, cmp_clr, cmp_en;
  logic [17:0] dist_ham = '0;
  logic [17:0] dist_spam = '0;
  logic        busy, overflow, result_valid;
  logic [1:0]  result;

  always #5 clk = ~clk;

  hdc_classify_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .msg_char     (msg_char),
    .msg_last     (msg_last),
    .im_addr      (im_addr),
    .chunk_idx    (chunk_idx),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .acc_last     (acc_last),
    .thr_en       (thr_en),
    .cmp_clr      (cmp_clr),
    .cmp_en       (cmp_en),
    .dist_ham     (dist_ham),
    .dist_spam    (dist_spam),
    .busy         (busy),
    .overflow     (overflow),
    .result_valid (result_valid),
    .result       (result)
  );

  typedef struct packed {
    logic       busy, ready, ovf, rv;
    logic [1:0] res;
    logic       clr, acc, last, thr, cclr, cen;
    logic [5:0] addr;
    logic [6:0] chunk;
  } obs_t;

  obs_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         run_idx = 0;
  int         lat_seen = -1;
  int         acc_seen = 0;
  logic [1:0] model_res = 2'b11;

  function automatic logic [5:0] tok_of(input logic [7:0] c);
    if (c >= "a" && c <= "z") return 6'(c - "a" + 8'd11);
    if (c >= "A" && c <= "Z") return 6'(c - "A" + 8'd11);
    if (c >= "0" && c <= "9") return 6'(c - "0" + 8'd1);
    return 6'd0;
  endfunction

  function automatic logic [1:0] verdict(input int h, input int s);
    if (h < s) return 2'b01;
    if (h > s) return 2'b00;
    return 2'b11;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected cycle-by-cycle outputs from the accept edge of the last char onward.
  task automatic plan(input logic [5:0] toks[$], input bit ovf, input logic [1:0] res);
    obs_t e;
    int   n = toks.size();
    e = '0; e.busy = 1'b1; e.ovf = ovf; e.res = model_res;
    for (int c = 0; c < NCH; c++) begin
      e.clr = 1'b1; e.chunk = 7'(c); exp_q.push_back(e);
    end
    e.clr = 1'b0;
    for (int i = 0; i < n; i++)
      for (int c = 0; c < NCH; c++) begin
        e.acc = 1'b1; e.addr = toks[i]; e.last = (i == n - 1); e.chunk = 7'(c);
        exp_q.push_back(e);
      end
    e.acc = 1'b0; e.last = 1'b0; e.addr = '0;
    for (int c = 0; c < NCH; c++) begin
      e.thr = 1'b1; e.chunk = 7'(c); exp_q.push_back(e);
    end
    e.thr = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      e.cen = 1'b1; e.cclr = (c == 0); e.chunk = 7'(c); exp_q.push_back(e);
    end
    e.cen = 1'b0; e.cclr = 1'b0; e.chunk = '0;
    for (int k = 0; k < DPL + 1; k++) exp_q.push_back(e);
    e.busy = 1'b0; e.ready = 1'b1; e.rv = 1'b1; e.res = res;
    exp_q.push_back(e);
    model_res = res;
  endtask

  task automatic send(input string s, input int h, input int sp);
    logic [5:0] toks[$];
    dist_ham  = 18'(h);
    dist_spam = 18'(sp);
    for (int i = 0; i < s.len() && i < MAXL; i++) toks.push_back(tok_of(s[i]));
    @(posedge clk); #1;
    chk("ready_in_load", {31'd0, msg_ready}, 32'd1);
    for (int i = 0; i < s.len(); i++) begin
      msg_valid = 1'b1;
      msg_char  = s[i];
      msg_last  = (i == s.len() - 1);
      @(posedge clk); #1;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    run_idx  = 0;
    acc_seen = 0;
    lat_seen = -1;
    plan(toks, s.len() > MAXL, verdict(h, sp));
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL timeout: %0d expected cycles left, wanted 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = {busy, msg_ready, overflow, result_valid, result, acc_clr, acc_en, acc_last,
           thr_en, cmp_clr, cmp_en, (e.acc ? im_addr : 6'd0), chunk_idx};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle %0d outputs: got %h expected %h", run_idx, a, e);
      end
      if (acc_en) acc_seen++;
      if (result_valid) lat_seen = run_idx;
      run_idx++;
    end
  end

  initial begin
    string big;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, msg_ready}, 32'd1);
    chk("rst_strobes", {26'd0, acc_clr, acc_en, acc_last, thr_en, cmp_clr, cmp_en}, 32'd0);
    chk("rst_result", {30'd0, result}, 32'd3);
    chk("rst_flags", {30'd0, overflow, result_valid}, 32'd0);
    chk("rst_chunk", {25'd0, chunk_idx}, 32'd0);
    chk("tok_H", {26'd0, tok_of("H")}, 32'd18);
    chk("tok_9", {26'd0, tok_of("9")}, 32'd10);
    chk("tok_hash", {26'd0, tok_of("#")}, 32'd0);
    reset = 1'b1;

    // "Hi" with a character held on the bus while busy.
    send("Hi", 40000, 50000);
    repeat (10) @(posedge clk);
    #1;
    msg_valid = 1'b1; msg_char = "x"; msg_last = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    msg_valid = 1'b0; msg_last = 1'b0;
    wait_done(1000);
    chk("hi_latency", lat_seen, 503);
    chk("hi_acc_cycles", acc_seen, 200);
    chk("hi_result", {30'd0, result}, 32'd1);

    send("Hi", 50000, 40000);
    wait_done(1000);
    chk("swap_result", {30'd0, result}, 32'd0);

    send("Hi", 45000, 45000);
    wait_done(1000);
    chk("equal_result", {30'd0, result}, 32'd3);

    big = "";
    for (int i = 0; i < 67; i++) big = {big, "A9#"};
    send(big, 10, 20);
    wait_done(25000);
    chk("ovf_acc_cycles", acc_seen, 20000);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_result", {30'd0, result}, 32'd1);

    // Back-to-back: overflow must drop with the next message.
    send("ok", 7, 3);
    wait_done(1000);
    chk("b2b_result", {30'd0, result}, 32'd0);
    chk("b2b_ovf", {31'd0, overflow}, 32'd0);

    // Reset in the middle of ACCUM.
    send("abc", 1, 2);
    repeat (150) @(posedge clk);
    #1;
    exp_q.delete();
    #2 reset = 1'b0;
    #1;
    chk("midrst_strobes", {26'd0, acc_clr, acc_en, acc_last, thr_en, cmp_clr, cmp_en}, 32'd0);
    chk("midrst_ready", {31'd0, msg_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_result", {30'd0, result}, 32'd3);
    model_res = 2'b11;
    @(posedge clk);
    #2 reset = 1'b1;
    send("z", 9, 5);
    wait_done(1000);
    chk("z_latency", lat_seen, 403);
    chk("z_result", {30'd0, result}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
